// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: controller state encoding
// and the width of one adder slice.
package nibble_serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/nibble_serial_add_ctrl_fa_4bit.sv
// Single 4-bit adder slice: the only arithmetic hardware in the serial adder.
module fa_4bit
   import nibble_serial_add_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle (LSB nibble first) through a
// single 4-bit slice, with valid/ready handshakes on both sides.
module nibble_serial_add_ctrl
   import nibble_serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int unsigned NIB = WIDTH / NIB_W;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             amsb;
   logic             bmsb;
   logic             accept;
   logic             last;
   logic [NIB_W-1:0] slice_sum;
   logic             slice_cout;

   fa_4bit u_slice (
      .a    (opa[NIB_W-1:0]),
      .b    (opb[NIB_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == CW'(NIB - 1));

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (accept)    state_n = ST_RUN;
         ST_RUN:  if (last)      state_n = ST_DONE;
         ST_DONE: if (out_ready) state_n = ST_IDLE;
         default:                state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         opa   <= '0;
         opb   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         amsb  <= 1'b0;
         bmsb  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  opa   <= a;
                  opb   <= b;
                  carry <= cin;
                  cnt   <= '0;
                  amsb  <= a[WIDTH-1];
                  bmsb  <= b[WIDTH-1];
               end
            end
            ST_RUN: begin
               // After NIB shifts the first slice result has reached sum[3:0].
               sum   <= {slice_sum, sum[WIDTH-1:NIB_W]};
               carry <= slice_cout;
               opa   <= opa >> NIB_W;
               opb   <= opb >> NIB_W;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  cout <= slice_cout;
                  ovf  <= (amsb == bmsb) && (slice_sum[NIB_W-1] != amsb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
